adder_result_checker: RTL and testbench

Synthesizable response checker for the pipelined adder. It is the receiving end of the adder's stimulus path: the same operand stream driven into `pipelined_adder` is tapped here. The checker delays a locally computed reference sum by the adder's register depth and compares it against the adder output. It keeps pass/fail counts, captures the first mismatch, and signals end of test, so benches and on-chip self-test both reduce to reading a few registers.

---
 rtl/adder_tb_pkg.sv | 20 ++
 rtl/adder_ref_delay.sv | 55 +++++
 rtl/adder_result_checker.sv | 150 +++++++++++++++
 tb/tb_adder_result_checker.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/adder_tb_pkg.sv
// Shared types and constants for the pipelined-adder response checker.
package adder_tb_pkg;

  // Checker FSM states.
  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DONE = 2'b10
  } state_e;

  // Legal adder latency range.
  localparam int unsigned NUM_REG_MIN = 32'd1;
  localparam int unsigned NUM_REG_MAX = 32'd8;

  // Counter width able to hold the values 0..num_checks.
  function automatic int unsigned cnt_width(input int unsigned num_checks);
    return $clog2(num_checks + 32'd1);
  endfunction

endpackage

// File: rtl/adder_ref_delay.sv
// NUM_REG-deep shift register of {valid, data} that aligns the reference
// sum with the adder output. Clear drops every in-flight entry; freeze
// holds the whole line.
module adder_ref_delay #(
  parameter int unsigned DW    = 4,
  parameter int unsigned DEPTH = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          freeze,
  input  logic          in_valid,
  input  logic [DW-1:0] in_data,
  output logic          out_valid,
  output logic [DW-1:0] out_data
);

  logic [DEPTH-1:0] valid_q;
  logic [DEPTH-1:0] valid_d;
  logic [DW-1:0]    data_q [DEPTH];
  logic [DW-1:0]    data_d [DEPTH];

  // Next line contents: shift one stage per cycle unless frozen.
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (freeze) begin
      valid_d = valid_q;
      data_d  = data_q;
    end else begin
      valid_d[0] = in_valid;
      data_d[0]  = in_data;
      for (int i = 1; i < int'(DEPTH); i++) begin
        valid_d[i] = valid_q[i-1];
        data_d[i]  = data_q[i-1];
      end
    end
  end

  // Line registers with synchronous active-low clear.
  always_ff @(posedge clk) begin
    if (!rst) begin
      valid_q <= '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        data_q[i] <= '0;
      end
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign out_valid = valid_q[DEPTH-1];
  assign out_data  = data_q[DEPTH-1];

endmodule

// File: rtl/adder_result_checker.sv
// Response checker for the pipelined adder: recomputes the sum from the
// tapped operand stream, delays it by the adder latency and compares it
// with the adder output. Keeps pass/fail counts, the first mismatch and
// an end-of-test flag.
module adder_result_checker
  import adder_tb_pkg::*;
#(
  parameter  int unsigned INP_DW     = 3,
  parameter  int unsigned NUM_REG    = 2,
  parameter  int unsigned NUM_CHECKS = 16,
  localparam int unsigned CNT_W      = cnt_width(NUM_CHECKS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [INP_DW-1:0] inp1,
  input  logic [INP_DW-1:0] inp2,
  input  logic [INP_DW:0]   outp,
  output logic [CNT_W-1:0]  pass_cnt,
  output logic [CNT_W-1:0]  fail_cnt,
  output logic              err,
  output logic [INP_DW:0]   err_exp,
  output logic [INP_DW:0]   err_got,
  output logic              done
);

  if ((NUM_REG < NUM_REG_MIN) || (NUM_REG > NUM_REG_MAX)) begin : g_bad_num_reg
    $error("adder_result_checker: NUM_REG out of range");
  end
  if (NUM_CHECKS < 32'd1) begin : g_bad_num_checks
    $error("adder_result_checker: NUM_CHECKS must be at least 1");
  end

  localparam logic [CNT_W:0] LIMIT = (CNT_W+1)'(NUM_CHECKS);

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    pass_cnt_q, pass_cnt_d;
  logic [CNT_W-1:0]    fail_cnt_q, fail_cnt_d;
  logic                err_q, err_d;
  logic [INP_DW:0]     err_exp_q, err_exp_d;
  logic [INP_DW:0]     err_got_q, err_got_d;
  logic                done_q, done_d;

  logic [INP_DW:0]     exp_s;
  logic                freeze_s;
  logic                ref_valid_s;
  logic [INP_DW:0]     ref_data_s;
  logic [CNT_W:0]      total_next_s;

  // The sum is computed one bit wider than the operands, so it cannot wrap.
  assign exp_s    = {1'b0, inp1} + {1'b0, inp2};
  assign freeze_s = (state_q == ST_DONE);

  adder_ref_delay #(
    .DW    (INP_DW + 1),
    .DEPTH (NUM_REG)
  ) u_ref_delay (
    .clk       (clk),
    .rst       (rst),
    .freeze    (freeze_s),
    .in_valid  (en),
    .in_data   (exp_s),
    .out_valid (ref_valid_s),
    .out_data  (ref_data_s)
  );

  // Compare count including the compare firing this cycle.
  assign total_next_s = {1'b0, pass_cnt_q} + {1'b0, fail_cnt_q} + (CNT_W+1)'(1);

  // FSM next state, compare, counters and first-error capture.
  always_comb begin
    state_d    = state_q;
    pass_cnt_d = pass_cnt_q;
    fail_cnt_d = fail_cnt_q;
    err_d      = err_q;
    err_exp_d  = err_exp_q;
    err_got_d  = err_got_q;
    done_d     = done_q;
    case (state_q)
      ST_IDLE: begin
        if (en) begin
          state_d = ST_RUN;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (ref_valid_s) begin
          if (outp == ref_data_s) begin
            pass_cnt_d = pass_cnt_q + CNT_W'(1);
          end else begin
            fail_cnt_d = fail_cnt_q + CNT_W'(1);
            // Only the first mismatch is kept for post-mortem.
            if (!err_q) begin
              err_d     = 1'b1;
              err_exp_d = ref_data_s;
              err_got_d = outp;
            end else begin
              err_d = err_q;
            end
          end
          if (total_next_s == LIMIT) begin
            state_d = ST_DONE;
            done_d  = 1'b1;
          end else begin
            state_d = ST_RUN;
          end
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_DONE: begin
        state_d = ST_DONE;
        done_d  = 1'b1;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and result registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      pass_cnt_q <= '0;
      fail_cnt_q <= '0;
      err_q      <= 1'b0;
      err_exp_q  <= '0;
      err_got_q  <= '0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      pass_cnt_q <= pass_cnt_d;
      fail_cnt_q <= fail_cnt_d;
      err_q      <= err_d;
      err_exp_q  <= err_exp_d;
      err_got_q  <= err_got_d;
      done_q     <= done_d;
    end
  end

  assign pass_cnt = pass_cnt_q;
  assign fail_cnt = fail_cnt_q;
  assign err      = err_q;
  assign err_exp  = err_exp_q;
  assign err_got  = err_got_q;
  assign done     = done_q;

endmodule

// File: tb/tb_adder_result_checker.sv
// Scoreboard bench for adder_result_checker (INP_DW=3, NUM_REG=2).
// Two instances share the stimulus: one with NUM_CHECKS=16, one with 4.
module tb_adder_result_checker;

  localparam int NUM_REG = 2;

  typedef struct packed {
    logic       v;
    logic [3:0] exp;
    logic [3:0] got;
  } ent_t;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       en = 1'b0;
  logic [2:0] inp1 = 3'd0;
  logic [2:0] inp2 = 3'd0;
  logic [3:0] outp = 4'd0;

  logic [4:0] pass16, fail16;
  logic       err16, done16;
  logic [3:0] eexp16, egot16;
  logic [2:0] pass4, fail4;
  logic       err4, done4;
  logic [3:0] eexp4, egot4;

  logic       sel4 = 1'b0;
  logic [4:0] obs_pass, obs_fail;
  logic       obs_err, obs_done;
  logic [3:0] obs_eexp, obs_egot;

  int   total = 0;
  int   bad = 0;
  ent_t sb[$];
  logic [3:0] resp_q[$];
  int   m_pass, m_fail, m_limit;
  logic m_err, m_done;
  logic [3:0] m_eexp, m_egot;

  adder_result_checker #(.INP_DW(3), .NUM_REG(NUM_REG), .NUM_CHECKS(16)) dut (
    .clk(clk), .rst(rst), .en(en), .inp1(inp1), .inp2(inp2), .outp(outp),
    .pass_cnt(pass16), .fail_cnt(fail16), .err(err16),
    .err_exp(eexp16), .err_got(egot16), .done(done16)
  );

  adder_result_checker #(.INP_DW(3), .NUM_REG(NUM_REG), .NUM_CHECKS(4)) dut4 (
    .clk(clk), .rst(rst), .en(en), .inp1(inp1), .inp2(inp2), .outp(outp),
    .pass_cnt(pass4), .fail_cnt(fail4), .err(err4),
    .err_exp(eexp4), .err_got(egot4), .done(done4)
  );

  always #5 clk = ~clk;

  assign obs_pass = sel4 ? {2'b00, pass4} : pass16;
  assign obs_fail = sel4 ? {2'b00, fail4} : fail16;
  assign obs_err  = sel4 ? err4  : err16;
  assign obs_done = sel4 ? done4 : done16;
  assign obs_eexp = sel4 ? eexp4 : eexp16;
  assign obs_egot = sel4 ? egot4 : egot16;

  // Hold reset for n edges with live random traffic, then clear bench state.
  task automatic do_reset(input int n);
    rst = 1'b0;
    for (int i = 0; i < n; i++) begin
      en   = 1'b1;
      inp1 = 3'($urandom_range(0, 7));
      inp2 = 3'($urandom_range(0, 7));
      outp = 4'($urandom_range(0, 15));
      @(posedge clk);
      #1;
    end
    rst = 1'b1;
    en = 1'b0; inp1 = 3'd0; inp2 = 3'd0; outp = 4'd0;
    sb.delete();
    resp_q.delete();
    for (int i = 0; i < NUM_REG; i++) resp_q.push_back(4'd0);
    m_pass = 0; m_fail = 0; m_err = 1'b0; m_done = 1'b0;
    m_eexp = 4'd0; m_egot = 4'd0;
    m_limit = sel4 ? 4 : 16;
  endtask

  // One clock: launch a pair (resp is the adder answer NUM_REG cycles later),
  // then pop the pair due at this edge and compare DUT state to the model.
  task automatic cycle(input logic e, input logic [2:0] a, input logic [2:0] b,
                       input logic [3:0] resp);
    ent_t ent;
    en   = e;
    inp1 = a;
    inp2 = b;
    outp = resp_q.pop_front();
    resp_q.push_back(resp);
    ent.v   = e;
    ent.exp = {1'b0, a} + {1'b0, b};
    ent.got = resp;
    sb.push_back(ent);
    @(posedge clk);
    #1;
    if (sb.size() > NUM_REG) begin
      ent = sb.pop_front();
      if (ent.v && !m_done) begin
        if (ent.got == ent.exp) begin
          m_pass++;
        end else begin
          m_fail++;
          if (!m_err) begin
            m_err = 1'b1; m_eexp = ent.exp; m_egot = ent.got;
          end
        end
        if (m_pass + m_fail == m_limit) m_done = 1'b1;
      end
      if (ent.v) begin
        total++;
        if (obs_pass !== 5'(m_pass)) begin
          bad++; $display("FAIL sb_pass got=%0d want=%0d t=%0t", obs_pass, m_pass, $time);
        end
        total++;
        if (obs_fail !== 5'(m_fail)) begin
          bad++; $display("FAIL sb_fail got=%0d want=%0d t=%0t", obs_fail, m_fail, $time);
        end
        total++;
        if (obs_err !== m_err || obs_eexp !== m_eexp || obs_egot !== m_egot) begin
          bad++;
          $display("FAIL sb_err got=%b/%0d/%0d want=%b/%0d/%0d t=%0t", obs_err, obs_eexp,
                   obs_egot, m_err, m_eexp, m_egot, $time);
        end
        total++;
        if (obs_done !== m_done) begin
          bad++; $display("FAIL sb_done got=%b want=%b t=%0t", obs_done, m_done, $time);
        end
      end
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 3'd0, 3'd0, 4'd0);
  endtask

  task automatic test_reset;
    sel4 = 1'b0;
    do_reset(2);
    total++;
    if (obs_pass !== 5'd0 || obs_fail !== 5'd0) begin
      bad++; $display("FAIL reset_cnt got=%0d/%0d want=0/0", obs_pass, obs_fail);
    end
    total++;
    if (obs_err !== 1'b0 || obs_eexp !== 4'd0 || obs_egot !== 4'd0) begin
      bad++; $display("FAIL reset_err got=%b/%0d/%0d want=0/0/0", obs_err, obs_eexp, obs_egot);
    end
    total++;
    if (obs_done !== 1'b0 || done4 !== 1'b0) begin
      bad++; $display("FAIL reset_done got=%b/%b want=0/0", obs_done, done4);
    end
    idle(3);
    total++;
    if (obs_pass !== 5'd0 || obs_fail !== 5'd0) begin
      bad++; $display("FAIL reset_nocount got=%0d/%0d want=0/0", obs_pass, obs_fail);
    end
  endtask

  task automatic test_single;
    do_reset(1);
    cycle(1'b1, 3'd3, 3'd4, 4'd7);
    cycle(1'b0, 3'd0, 3'd0, 4'd0);
    total++;
    if (obs_pass !== 5'd0) begin
      bad++; $display("FAIL single_latency got=%0d want=0", obs_pass);
    end
    cycle(1'b0, 3'd0, 3'd0, 4'd0);
    total++;
    if (obs_pass !== 5'd1 || obs_fail !== 5'd0 || obs_err !== 1'b0) begin
      bad++; $display("FAIL single_add got=%0d/%0d/%b want=1/0/0", obs_pass, obs_fail, obs_err);
    end
  endtask

  task automatic test_width;
    do_reset(1);
    cycle(1'b1, 3'd7, 3'd7, 4'b1110);
    cycle(1'b1, 3'd0, 3'd0, 4'd0);
    idle(2);
    total++;
    if (obs_pass !== 5'd2 || obs_fail !== 5'd0) begin
      bad++; $display("FAIL width_pass got=%0d/%0d want=2/0", obs_pass, obs_fail);
    end
    do_reset(1);
    cycle(1'b1, 3'd7, 3'd7, 4'b0110);
    idle(2);
    total++;
    if (obs_fail !== 5'd1 || obs_eexp !== 4'd14 || obs_egot !== 4'd6) begin
      bad++; $display("FAIL width_msb got=%0d/%0d/%0d want=1/14/6", obs_fail, obs_eexp, obs_egot);
    end
  endtask

  task automatic test_first_err;
    do_reset(1);
    cycle(1'b1, 3'd5, 3'd1, 4'd5);
    cycle(1'b1, 3'd2, 3'd2, 4'd0);
    idle(1);
    total++;
    if (obs_err !== 1'b1 || obs_fail !== 5'd1) begin
      bad++; $display("FAIL first_err_edge got=%b/%0d want=1/1", obs_err, obs_fail);
    end
    idle(1);
    total++;
    if (obs_fail !== 5'd2 || obs_err !== 1'b1 || obs_eexp !== 4'd6 || obs_egot !== 4'd5) begin
      bad++;
      $display("FAIL first_err_keep got=%0d/%b/%0d/%0d want=2/1/6/5", obs_fail, obs_err,
               obs_eexp, obs_egot);
    end
  endtask

  task automatic test_bubbles;
    do_reset(1);
    cycle(1'b1, 3'd1, 3'd2, 4'd3);
    cycle(1'b0, 3'd0, 3'd0, 4'hF);
    cycle(1'b1, 3'd6, 3'd1, 4'd7);
    idle(3);
    total++;
    if (obs_pass !== 5'd2 || obs_fail !== 5'd0) begin
      bad++; $display("FAIL bubble got=%0d/%0d want=2/0", obs_pass, obs_fail);
    end
    do_reset(1);
    cycle(1'b1, 3'd3, 3'd3, 4'd6);
    do_reset(1);
    idle(3);
    total++;
    if (obs_pass !== 5'd0 || obs_fail !== 5'd0) begin
      bad++; $display("FAIL reset_mid got=%0d/%0d want=0/0", obs_pass, obs_fail);
    end
  endtask

  task automatic test_back_to_back;
    logic [2:0] a, b;
    logic [3:0] r;
    int exp_pass = 0;
    int exp_fail = 0;
    do_reset(1);
    for (int i = 0; i < 12; i++) begin
      a = 3'($urandom_range(0, 7));
      b = 3'($urandom_range(0, 7));
      r = {1'b0, a} + {1'b0, b};
      if ($urandom_range(0, 3) == 0) begin
        r = r ^ 4'($urandom_range(1, 15));
        exp_fail++;
      end else begin
        exp_pass++;
      end
      cycle(1'b1, a, b, r);
    end
    idle(2);
    total++;
    if (obs_pass !== 5'(exp_pass) || obs_fail !== 5'(exp_fail)) begin
      bad++;
      $display("FAIL b2b got=%0d/%0d want=%0d/%0d", obs_pass, obs_fail, exp_pass, exp_fail);
    end
  endtask

  task automatic test_done;
    logic [2:0] a, b;
    sel4 = 1'b1;
    do_reset(1);
    for (int i = 0; i < 6; i++) begin
      a = 3'(i + 1);
      b = 3'(6 - i);
      cycle(1'b1, a, b, {1'b0, a} + {1'b0, b});
      if (i == 4) begin
        total++;
        if (obs_done !== 1'b0 || obs_pass !== 5'd3) begin
          bad++; $display("FAIL done_early got=%b/%0d want=0/3", obs_done, obs_pass);
        end
      end
      if (i == 5) begin
        total++;
        if (obs_done !== 1'b1 || obs_pass !== 5'd4) begin
          bad++; $display("FAIL done_rise got=%b/%0d want=1/4", obs_done, obs_pass);
        end
      end
    end
    idle(2);
    cycle(1'b1, 3'd1, 3'd1, 4'd0);
    cycle(1'b1, 3'd2, 3'd2, 4'd0);
    idle(3);
    total++;
    if (obs_done !== 1'b1 || obs_pass !== 5'd4 || obs_fail !== 5'd0 || obs_err !== 1'b0) begin
      bad++;
      $display("FAIL done_freeze got=%b/%0d/%0d/%b want=1/4/0/0", obs_done, obs_pass,
               obs_fail, obs_err);
    end
    sel4 = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_width();
    test_first_err();
    test_bubbles();
    test_back_to_back();
    test_done();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
